// File: rtl/debug_controller_pkg.sv
// Shared constants for the UART debug sequencer: widths, command codes and FSM states.
package debug_controller_pkg;

    localparam int unsigned PC_BITS          = 32;
    localparam int unsigned INSTRUCTION_BITS = 32;
    localparam int unsigned PROC_BITS        = 32;
    localparam int unsigned NUM_REGS         = 32;
    localparam int unsigned CNT_BITS         = 32;

    localparam int unsigned DUMP_BYTES = 4 + 4 * NUM_REGS;
    localparam int unsigned IDX_BITS   = $clog2(DUMP_BYTES);
    localparam int unsigned WIDX_BITS  = IDX_BITS - 2;
    localparam int unsigned WCNT_BITS  = 9;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_STEP = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_CNT,
        ST_LOAD_BYTE,
        ST_LOAD_WRITE,
        ST_RUN,
        ST_STEP,
        ST_DUMP_SEND,
        ST_DUMP_WAIT
    } state_e;

endpackage

// File: rtl/debug_controller_byte_assembler.sv
// Shifts received bytes MSB-first into an instruction word; last_c flags the 4th byte.
module debug_controller_byte_assembler
    import debug_controller_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr_i,
    input  logic                        valid_i,
    input  logic [7:0]                  byte_i,
    output logic [INSTRUCTION_BITS-1:0] word_o,
    output logic                        last_c
);

    logic [1:0]                  cnt_q;
    logic [INSTRUCTION_BITS-1:0] word_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (clr_i) begin
            cnt_q  <= '0;
        end else if (valid_i) begin
            word_q <= {word_q[INSTRUCTION_BITS-9:0], byte_i};
            cnt_q  <= cnt_q + 2'd1;
        end
    end

    assign last_c = valid_i && (cnt_q == 2'd3);
    assign word_o = word_q;

endmodule

// File: rtl/debug_controller.sv
// Host command sequencer: loads instruction memory, runs/steps the datapath and
// streams the cycle counter plus register file back over UART.
module debug_controller
    import debug_controller_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    i_rx_data,
    input  logic                          i_rx_done,
    input  logic                          i_tx_done,
    input  logic                          i_halt,
    input  logic [NUM_REGS*PROC_BITS-1:0] i_rf_regs,
    output logic                          o_tx_start,
    output logic [7:0]                    o_tx_data,
    output logic                          o_enable,
    output logic                          o_dp_rst,
    output logic                          o_write_inst_mem,
    output logic [PC_BITS-1:0]            o_inst_mem_addr,
    output logic [INSTRUCTION_BITS-1:0]   o_inst_mem_data,
    output logic                          o_halted
);

    state_e                state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [PC_BITS-1:0]    addr_q, addr_d;
    logic                  halted_q, halted_d;
    logic [WCNT_BITS-1:0]  words_q, words_d;
    logic [IDX_BITS-1:0]   idx_q, idx_d;
    logic                  enable_q, enable_d;
    logic                  dp_rst_q, dp_rst_d;
    logic                  wr_q, wr_d;
    logic                  tx_start_q, tx_start_d;
    logic [7:0]            tx_data_q, tx_data_d;

    logic                        asm_clr;
    logic                        asm_valid;
    logic                        asm_last_c;
    logic [INSTRUCTION_BITS-1:0] asm_word;
    logic [PROC_BITS-1:0]        dump_word_c;
    logic [7:0]                  dump_byte_c;

    debug_controller_byte_assembler u_asm (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (asm_clr),
        .valid_i (asm_valid),
        .byte_i  (i_rx_data),
        .word_o  (asm_word),
        .last_c  (asm_last_c)
    );

    // Dump word 0 is the cycle counter, word k+1 is register k; bytes go MSB first.
    always_comb begin
        dump_word_c = cnt_q;
        for (int k = 0; k < int'(NUM_REGS); k++) begin
            if (idx_q[IDX_BITS-1:2] == WIDX_BITS'(k + 1)) begin
                dump_word_c = i_rf_regs[k*PROC_BITS +: PROC_BITS];
            end
        end
        case (idx_q[1:0])
            2'd0:    dump_byte_c = dump_word_c[31:24];
            2'd1:    dump_byte_c = dump_word_c[23:16];
            2'd2:    dump_byte_c = dump_word_c[15:8];
            default: dump_byte_c = dump_word_c[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            halted_q   <= 1'b0;
            words_q    <= '0;
            idx_q      <= '0;
            enable_q   <= 1'b0;
            dp_rst_q   <= 1'b0;
            wr_q       <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            halted_q   <= halted_d;
            words_q    <= words_d;
            idx_q      <= idx_d;
            enable_q   <= enable_d;
            dp_rst_q   <= dp_rst_d;
            wr_q       <= wr_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        halted_d   = halted_q;
        words_d    = words_q;
        idx_d      = idx_q;
        enable_d   = 1'b0;
        dp_rst_d   = 1'b0;
        wr_d       = 1'b0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        asm_clr    = 1'b0;
        asm_valid  = 1'b0;

        // Saturating count of every enabled datapath cycle.
        if (enable_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_BITS'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (i_rx_done) begin
                    case (i_rx_data)
                        CMD_LOAD: begin
                            state_d  = ST_LOAD_CNT;
                            dp_rst_d = 1'b1;
                            cnt_d    = '0;
                            addr_d   = '0;
                            halted_d = 1'b0;
                        end
                        CMD_RUN: begin
                            idx_d = '0;
                            if (halted_q) begin
                                state_d = ST_DUMP_SEND;
                            end else begin
                                state_d  = ST_RUN;
                                enable_d = 1'b1;
                            end
                        end
                        CMD_STEP: begin
                            idx_d = '0;
                            if (halted_q) begin
                                state_d = ST_DUMP_SEND;
                            end else begin
                                state_d  = ST_STEP;
                                enable_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD_CNT: begin
                if (i_rx_done) begin
                    words_d = (i_rx_data == 8'h00) ? WCNT_BITS'(256) : WCNT_BITS'(i_rx_data);
                    asm_clr = 1'b1;
                    state_d = ST_LOAD_BYTE;
                end
            end
            ST_LOAD_BYTE: begin
                asm_valid = i_rx_done;
                if (asm_last_c) begin
                    state_d = ST_LOAD_WRITE;
                    wr_d    = 1'b1;
                end
            end
            ST_LOAD_WRITE: begin
                addr_d  = addr_q + PC_BITS'(4);
                words_d = words_q - WCNT_BITS'(1);
                state_d = (words_q == WCNT_BITS'(1)) ? ST_IDLE : ST_LOAD_BYTE;
            end
            ST_RUN: begin
                // Halt has priority; any byte arriving now is simply dropped.
                if (i_halt) begin
                    halted_d = 1'b1;
                    state_d  = ST_DUMP_SEND;
                end else begin
                    enable_d = 1'b1;
                end
            end
            ST_STEP: begin
                if (i_halt) begin
                    halted_d = 1'b1;
                end
                state_d = ST_DUMP_SEND;
            end
            ST_DUMP_SEND: begin
                tx_start_d = 1'b1;
                tx_data_d  = dump_byte_c;
                state_d    = ST_DUMP_WAIT;
            end
            ST_DUMP_WAIT: begin
                if (i_tx_done) begin
                    if (idx_q == IDX_BITS'(DUMP_BYTES - 1)) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_BITS'(1);
                        state_d = ST_DUMP_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_tx_start       = tx_start_q;
    assign o_tx_data        = tx_data_q;
    assign o_enable         = enable_q;
    assign o_dp_rst         = dp_rst_q;
    assign o_write_inst_mem = wr_q;
    assign o_inst_mem_addr  = addr_q;
    assign o_inst_mem_data  = asm_word;
    assign o_halted         = halted_q;

endmodule

// File: tb/tb_debug_controller.sv
// Randomized bench for debug_controller against a transaction-level host/datapath model.
module tb_debug_controller;

    localparam int DUMP_N = 132;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   i_rx_data = 8'h00;
    logic         i_rx_done = 1'b0;
    logic         i_tx_done;
    logic         i_halt = 1'b0;
    logic [1023:0] i_rf_regs;
    logic         o_tx_start;
    logic [7:0]   o_tx_data;
    logic         o_enable;
    logic         o_dp_rst;
    logic         o_write_inst_mem;
    logic [31:0]  o_inst_mem_addr;
    logic [31:0]  o_inst_mem_data;
    logic         o_halted;

    logic [31:0]  regs [32];
    logic         resp_done = 1'b0;
    logic         man_done = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // Host-side observations
    logic [7:0]   tx_q[$];
    logic [31:0]  wa_q[$];
    logic [31:0]  wd_q[$];
    int           en_total = 0;
    int           dprst_total = 0;
    int           tx_pend = 0;

    // Reference model state
    longint       m_cnt = 0;
    bit           m_halted = 1'b0;
    logic [31:0]  m_addr = 32'h0;

    assign i_tx_done = resp_done | man_done;

    always_comb begin
        for (int k = 0; k < 32; k++) i_rf_regs[k*32 +: 32] = regs[k];
    end

    debug_controller dut (
        .clk              (clk),
        .rst              (rst),
        .i_rx_data        (i_rx_data),
        .i_rx_done        (i_rx_done),
        .i_tx_done        (i_tx_done),
        .i_halt           (i_halt),
        .i_rf_regs        (i_rf_regs),
        .o_tx_start       (o_tx_start),
        .o_tx_data        (o_tx_data),
        .o_enable         (o_enable),
        .o_dp_rst         (o_dp_rst),
        .o_write_inst_mem (o_write_inst_mem),
        .o_inst_mem_addr  (o_inst_mem_addr),
        .o_inst_mem_data  (o_inst_mem_data),
        .o_halted         (o_halted)
    );

    always #5 clk = ~clk;

    // UART transmitter stand-in plus output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        resp_done = 1'b0;
        if (o_tx_start) begin
            tx_q.push_back(o_tx_data);
            tx_pend = 2;
        end else if (tx_pend != 0) begin
            tx_pend--;
            if (tx_pend == 0) resp_done = 1'b1;
        end
        if (o_enable) en_total++;
        if (o_dp_rst) dprst_total++;
        if (o_write_inst_mem) begin
            wa_q.push_back(o_inst_mem_addr);
            wd_q.push_back(o_inst_mem_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0;
    endtask

    task automatic rand_regs();
        for (int k = 0; k < 32; k++) regs[k] = $urandom;
    endtask

    function automatic logic [7:0] exp_dump_byte(input int b);
        logic [31:0] w;
        int          sh;
        if (b < 4) begin
            w  = 32'(m_cnt);
            sh = 8 * (3 - b);
        end else begin
            w  = regs[(b - 4) / 4];
            sh = 8 * (3 - ((b - 4) % 4));
        end
        return 8'(w >> sh);
    endfunction

    task automatic wait_dump(input int t0, input string tag);
        int budget = 3000;
        while (tx_q.size() < t0 + DUMP_N && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (10) @(negedge clk);
        check({tag, "_dump_len"}, 64'(tx_q.size() - t0), 64'(DUMP_N));
        if (tx_q.size() >= t0 + DUMP_N) begin
            for (int b = 0; b < DUMP_N; b++)
                check($sformatf("%s_dump_b%0d", tag, b), 64'(tx_q[t0 + b]), 64'(exp_dump_byte(b)));
        end
    endtask

    task automatic do_load(input logic [7:0] nb, input logic [31:0] words[$], input string tag);
        int n   = (nb == 8'h00) ? 256 : int'(nb);
        int w0  = wa_q.size();
        int d0  = dprst_total;
        int e0  = en_total;
        int t0  = tx_q.size();
        send_byte(8'h01);
        send_byte(nb);
        m_cnt = 0; m_halted = 1'b0; m_addr = 32'h0;
        for (int i = 0; i < n; i++)
            for (int j = 3; j >= 0; j--) send_byte(8'(words[i] >> (8 * j)));
        repeat (6) @(negedge clk);
        check({tag, "_writes"}, 64'(wa_q.size() - w0), 64'(n));
        check({tag, "_dp_rst"}, 64'(dprst_total - d0), 64'd1);
        check({tag, "_no_enable"}, 64'(en_total - e0), 64'd0);
        check({tag, "_no_tx"}, 64'(tx_q.size() - t0), 64'd0);
        check({tag, "_halted"}, 64'(o_halted), 64'd0);
        if (wa_q.size() - w0 == n) begin
            for (int i = 0; i < n; i++) begin
                check($sformatf("%s_addr%0d", tag, i), 64'(wa_q[w0 + i]), 64'(m_addr));
                check($sformatf("%s_data%0d", tag, i), 64'(wd_q[w0 + i]), 64'(words[i]));
                m_addr = m_addr + 32'd4;
            end
        end
    endtask

    task automatic do_load_rand(input int n, input string tag);
        logic [31:0] w[$];
        for (int i = 0; i < n; i++) w.push_back($urandom);
        do_load(8'(n), w, tag);
    endtask

    task automatic do_run(input int k, input string tag);
        int e0 = en_total;
        int t0 = tx_q.size();
        bit was_halted = m_halted;
        int seen = 0;
        int budget = k + 20;
        rand_regs();
        send_byte(8'h02);
        if (!was_halted) begin
            while (budget > 0) begin
                if (o_enable) begin
                    seen++;
                    if (seen == k) break;
                end
                @(negedge clk);
                budget--;
            end
            if (seen != k) check({tag, "_enable_timeout"}, 64'(seen), 64'(k));
            i_halt = 1'b1;
            @(negedge clk);
            i_halt = 1'b0;
            m_cnt = (m_cnt + k > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + k;
            m_halted = 1'b1;
        end
        wait_dump(t0, tag);
        check({tag, "_en_cycles"}, 64'(en_total - e0), was_halted ? 64'd0 : 64'(k));
        check({tag, "_halted"}, 64'(o_halted), 64'd1);
    endtask

    task automatic do_step(input bit hd, input string tag);
        int e0 = en_total;
        int t0 = tx_q.size();
        bit was_halted = m_halted;
        send_byte(8'h03);
        if (!was_halted) begin
            i_halt = hd;
            @(negedge clk);
            i_halt = 1'b0;
            m_cnt = (m_cnt == 64'hFFFF_FFFF) ? m_cnt : m_cnt + 1;
            m_halted = hd;
        end
        wait_dump(t0, tag);
        check({tag, "_en_cycles"}, 64'(en_total - e0), was_halted ? 64'd0 : 64'd1);
        check({tag, "_halted"}, 64'(o_halted), 64'(m_halted));
    endtask

    initial begin
        logic [31:0] w2[$];
        int          t0, e0, w0;

        rand_regs();
        repeat (3) @(negedge clk);
        check("rst_tx_start", 64'(o_tx_start), 64'd0);
        check("rst_enable", 64'(o_enable), 64'd0);
        check("rst_dp_rst", 64'(o_dp_rst), 64'd0);
        check("rst_write", 64'(o_write_inst_mem), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("init_tx_data", 64'(o_tx_data), 64'd0);
        check("init_addr", 64'(o_inst_mem_addr), 64'd0);
        check("init_data", 64'(o_inst_mem_data), 64'd0);
        check("init_halted", 64'(o_halted), 64'd0);

        // Reset in the middle of a LOAD aborts without any write strobe
        w0 = wa_q.size();
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'hAB);
        send_byte(8'hCD);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_write", 64'(o_write_inst_mem), 64'd0);
        check("midrst_dp_rst", 64'(o_dp_rst), 64'd0);
        check("midrst_addr", 64'(o_inst_mem_addr), 64'd0);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_no_strobe", 64'(wa_q.size() - w0), 64'd0);
        check("midrst_enable", 64'(o_enable), 64'd0);
        check("midrst_tx_start", 64'(o_tx_start), 64'd0);
        m_cnt = 0; m_halted = 1'b0; m_addr = 32'h0;

        w2.push_back(32'h2001_0005);
        w2.push_back(32'hFFFF_FFFF);
        do_load(8'd2, w2, "load2");
        do_run(7, "run7");
        check("run7_cnt_byte3", 64'(tx_q[tx_q.size() - DUMP_N + 3]), 64'h07);
        do_run(5, "run_halted");

        // Unknown command and stray tx_done pulses while idle
        t0 = tx_q.size();
        e0 = en_total;
        w0 = wa_q.size();
        send_byte(8'h7F);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            man_done = 1'b1;
            @(negedge clk);
            man_done = 1'b0;
        end
        repeat (5) @(negedge clk);
        check("bad_cmd_no_tx", 64'(tx_q.size() - t0), 64'd0);
        check("bad_cmd_no_en", 64'(en_total - e0), 64'd0);
        check("bad_cmd_no_wr", 64'(wa_q.size() - w0), 64'd0);
        check("bad_cmd_halted", 64'(o_halted), 64'd1);

        do_load_rand(1, "load1");
        rand_regs();
        regs[1] = 32'h0000_0005;
        for (int i = 0; i < 3; i++) do_step(1'b0, $sformatf("step%0d", i));

        do_load_rand(0, "load256");

        for (int op = 0; op < 30; op++) begin
            int r = $urandom_range(0, 9);
            if (r < 2) begin
                do_load_rand($urandom_range(1, 4), $sformatf("r%0d_load", op));
            end else if (r < 5) begin
                do_run($urandom_range(1, 20), $sformatf("r%0d_run", op));
            end else begin
                rand_regs();
                do_step($urandom_range(0, 9) == 0, $sformatf("r%0d_step", op));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/debug_controller.md
Name: debug_controller

Overview:
Sequencer sitting between the UART byte interface and the pipelined MIPS datapath. It decodes host commands to load instruction memory word by word, then runs the datapath continuously or single-steps it through the datapath enable. After each run/step it streams a status dump back over UART: cycle count plus all 32 register-file words.

Parameters:
PC_BITS, 32, width of instruction-memory address (byte address)
INSTRUCTION_BITS, 32, instruction word width
PROC_BITS, 32, register width
NUM_REGS, 32, registers in dump
CNT_BITS, 32, cycle-counter width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
i_rx_data  in  8  received UART byte
i_rx_done  in  1  1-cycle pulse, i_rx_data valid
i_tx_done  in  1  1-cycle pulse, UART transmitter finished byte
i_halt  in  1  datapath HALT instruction reached write-back
i_rf_regs  in  NUM_REGS*PROC_BITS  register file flat bus, reg k at [32k+31:32k]
o_tx_start  out  1  1-cycle pulse, start transmitting o_tx_data
o_tx_data  out  8  byte to transmit, held until i_tx_done
o_enable  out  1  datapath enable
o_dp_rst  out  1  active-high 1-cycle datapath pipeline reset
o_write_inst_mem  out  1  1-cycle instruction-memory write strobe
o_inst_mem_addr  out  PC_BITS  write address
o_inst_mem_data  out  INSTRUCTION_BITS  write data
o_halted  out  1  sticky halt status

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0, load address 0, halted 0. Reset mid-operation aborts any load/run/dump immediately with no further strobes.
- Commands, accepted only in IDLE on i_rx_done: 0x01 LOAD, 0x02 RUN, 0x03 STEP. Any other byte is ignored; the FSM stays in IDLE. Bytes arriving outside IDLE/LOAD states are dropped.
- States: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WRITE, RUN, STEP, DUMP_SEND, DUMP_WAIT.
- LOAD:
  - IDLE→LOAD_CNT: o_dp_rst pulses 1 cycle; counter, address and halted are cleared.
  - Next rx byte N gives the word count; N=0 means 256. State goes to LOAD_BYTE.
  - Each word is 4 bytes, MSB first, shifted into an assembler.
  - One cycle after the 4th byte: LOAD_WRITE drives o_write_inst_mem=1 for 1 cycle with the current address and word. The address then increments by 4, wrapping mod 2^PC_BITS.
  - After N words, return to IDLE. No dump is sent after LOAD.
- RUN:
  - If halted: go straight to DUMP_SEND.
  - Otherwise o_enable=1 from the cycle after the command. It stays high until i_halt is sampled 1. At that edge o_enable goes 0, halted is set and the FSM enters DUMP_SEND. The cycle in which i_halt is high is counted.
- STEP:
  - If halted: go straight to DUMP_SEND.
  - Otherwise o_enable=1 for exactly 1 cycle, then DUMP_SEND. i_halt sampled during that cycle sets halted.
- Cycle counter: increments on every cycle with o_enable=1 and saturates at all-ones.
- Dump: 4+4*NUM_REGS bytes (132 by default).
  - Order: counter MSB first, then reg0..reg31, each MSB first.
  - DUMP_SEND pulses o_tx_start 1 cycle with o_tx_data, then goes to DUMP_WAIT.
  - On i_tx_done, advance the byte index; after the last byte return to IDLE.
  - i_tx_done in any other state is ignored. i_rf_regs is sampled live; it is stable because o_enable=0.
- o_halted mirrors the halted flag and is cleared only by LOAD or reset.
- Simultaneous i_rx_done and i_halt in RUN: halt wins and the byte is dropped.

Decomposition:
- Shared constants header: command codes (CMD_LOAD, CMD_RUN, CMD_STEP), state encodings, DUMP_BYTES derived from NUM_REGS.
- One natural sub-module: byte_assembler, which shifts 4 rx bytes into a word and flags word-complete. It is reused with a byte counter by the load path.
- The dump byte mux stays inline.

Test Plan:
- Reset mid-LOAD after 2 bytes: no o_write_inst_mem, state IDLE, all outputs 0 after deassert.
- LOAD, N=2, words 0x20010005, 0xFFFFFFFF: writes addr 0 data 0x20010005, then addr 4 data 0xFFFFFFFF, exactly 2 strobes; o_dp_rst pulsed once.
- RUN with i_halt asserted on the 7th enabled cycle: o_enable high 7 cycles, o_halted=1, 132 bytes sent, first 4 = 00 00 00 07.
- STEP ×3 with regs preloaded (reg1=0x00000005): each step gives exactly 1 enable cycle; counter bytes read 1, 2, 3; bytes 8–11 read 00 00 00 05.
- RUN while halted: zero enable cycles, immediate dump with unchanged counter.
- Command 0x7F, then i_tx_done pulses in IDLE: no state change, no o_tx_start.
